// File: rtl/coef_wr_scheduler.sv
// ============================================================================
//  Module   : coef_wr_scheduler
//  Purpose  : Queues FIR coefficient / EQ gain register writes and replays them
//             into the shared coefficient RAM port when the engine grants it.
//  Options  : EQ_WR_PATH_EN - when defined, EQ writes are queued as well.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module coef_wr_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       coef_wr_stb,
    input  logic [7:0] coef_select_reg,
    input  logic [7:0] coef_wr_lsb_data_reg,
    input  logic [7:0] coef_wr_msb_data_reg,
    input  logic       eq_wr_stb,
    input  logic [7:0] eq_select_reg,
    input  logic [7:0] eq_wr_lsb_data_reg,
    input  logic [7:0] eq_wr_msb_data_reg,
    input  logic       ram_gnt,
    input  logic       ovf_clr,
    output logic       ram_req,
    output logic       ram_we,
    output logic       ram_sel,
    output logic [7:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic [4:0] pending,
    output logic       overflow,
    output logic       idle
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef struct packed {
        logic       sel;
        logic [7:0] addr;
        logic [7:0] msb;
        logic [7:0] lsb;
    } entry_t;

    // Reset asserts asynchronously but releases two edges later, in step with clk.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    state_t          state_q, state_d;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]      count_q, count_d;
    logic            overflow_q, overflow_d;

    logic            eq_req;
    entry_t          fir_entry;
    entry_t          eq_entry;
    entry_t          head;
    logic            pop;
    logic            fir_push;
    logic            eq_push;
    logic            drop;
    logic [4:0]      slots_free;

`ifdef EQ_WR_PATH_EN
    assign eq_req   = eq_wr_stb;
    assign eq_entry = '{sel: 1'b1, addr: eq_select_reg,
                        msb: eq_wr_msb_data_reg, lsb: eq_wr_lsb_data_reg};
`else
    logic unused_eq;
    assign unused_eq = ^{eq_wr_stb, eq_select_reg, eq_wr_lsb_data_reg, eq_wr_msb_data_reg};
    assign eq_req    = 1'b0;
    assign eq_entry  = '0;
`endif

    assign fir_entry = '{sel: 1'b0, addr: coef_select_reg,
                         msb: coef_wr_msb_data_reg, lsb: coef_wr_lsb_data_reg};
    assign head      = mem_q[rd_ptr_q];
    assign pop       = (state_q == WRITE);

    // Free slots count the head being retired this cycle; FIR wins the last slot.
    always_comb begin
        slots_free = DEPTH_C - count_q + 5'(pop);
        fir_push   = coef_wr_stb && (slots_free != 5'd0);
        eq_push    = eq_req && (slots_free > 5'(fir_push));
        drop       = (coef_wr_stb && !fir_push) || (eq_req && !eq_push);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (fir_push) begin
            mem_d[wr_ptr_q] = fir_entry;
        end
        if (eq_push) begin
            mem_d[wr_ptr_q + PW'(fir_push)] = eq_entry;
        end
        wr_ptr_d   = wr_ptr_q + PW'(fir_push) + PW'(eq_push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + 5'(fir_push) + 5'(eq_push) - 5'(pop);
        overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
    end

    // Next state looks at the post-push count so a strobe reaches REQ next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_d != 5'd0) state_d = REQ;
            REQ:     if (ram_gnt) state_d = WRITE;
            WRITE:   state_d = (count_d != 5'd0) ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        ram_req   = (state_q == REQ);
        ram_we    = pop;
        ram_sel   = pop ? head.sel : 1'b0;
        ram_addr  = pop ? head.addr : 8'h00;
        ram_wdata = pop ? {head.msb, head.lsb} : 16'h0000;
        pending   = count_q;
        overflow  = overflow_q;
        idle      = (state_q == IDLE) && (count_q == 5'd0);
    end

endmodule

`default_nettype wire

// File: tb/tb_coef_wr_scheduler.sv
// ============================================================================
//  Module   : tb_coef_wr_scheduler
//  Purpose  : Directed self-checking bench for coef_wr_scheduler (DEPTH = 4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coef_wr_scheduler;

    logic        clk;
    logic        reset_n;
    logic        coef_wr_stb;
    logic [7:0]  coef_select_reg;
    logic [7:0]  coef_wr_lsb_data_reg;
    logic [7:0]  coef_wr_msb_data_reg;
    logic        eq_wr_stb;
    logic [7:0]  eq_select_reg;
    logic [7:0]  eq_wr_lsb_data_reg;
    logic [7:0]  eq_wr_msb_data_reg;
    logic        ram_gnt;
    logic        ovf_clr;
    logic        ram_req;
    logic        ram_we;
    logic        ram_sel;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [4:0]  pending;
    logic        overflow;
    logic        idle;

    int checks;
    int failures;

    logic [7:0]  q_addr[$];
    logic [15:0] q_data[$];
    logic        q_sel[$];
    logic [4:0]  q_pend[$];
    logic        prev_granted;

    coef_wr_scheduler #(.DEPTH(4)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .coef_wr_stb          (coef_wr_stb),
        .coef_select_reg      (coef_select_reg),
        .coef_wr_lsb_data_reg (coef_wr_lsb_data_reg),
        .coef_wr_msb_data_reg (coef_wr_msb_data_reg),
        .eq_wr_stb            (eq_wr_stb),
        .eq_select_reg        (eq_select_reg),
        .eq_wr_lsb_data_reg   (eq_wr_lsb_data_reg),
        .eq_wr_msb_data_reg   (eq_wr_msb_data_reg),
        .ram_gnt              (ram_gnt),
        .ovf_clr              (ovf_clr),
        .ram_req              (ram_req),
        .ram_we               (ram_we),
        .ram_sel              (ram_sel),
        .ram_addr             (ram_addr),
        .ram_wdata            (ram_wdata),
        .pending              (pending),
        .overflow             (overflow),
        .idle                 (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and log any RAM write seen there.
    task automatic step();
        @(negedge clk);
        if (ram_we === 1'b1) begin
            q_addr.push_back(ram_addr);
            q_data.push_back(ram_wdata);
            q_sel.push_back(ram_sel);
            q_pend.push_back(pending);
        end else begin
            chk("ram_bus_zero_outside_write", {7'd0, ram_sel, ram_addr, ram_wdata}, 32'd0);
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_sel.delete();
        q_pend.delete();
    endtask

    task automatic fir(input logic [7:0] a, input logic [7:0] msb, input logic [7:0] lsb);
        coef_wr_stb          = 1'b1;
        coef_select_reg      = a;
        coef_wr_msb_data_reg = msb;
        coef_wr_lsb_data_reg = lsb;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b1;
        coef_wr_stb = 1'b0; coef_select_reg = 8'h00;
        coef_wr_lsb_data_reg = 8'h00; coef_wr_msb_data_reg = 8'h00;
        eq_wr_stb = 1'b0; eq_select_reg = 8'h00;
        eq_wr_lsb_data_reg = 8'h00; eq_wr_msb_data_reg = 8'h00;
        ram_gnt = 1'b0; ovf_clr = 1'b0;

        // Reset state
        #1 reset_n = 1'b0;
        #1;
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_pending", {27'd0, pending}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_req_we", {30'd0, ram_req, ram_we}, 32'd0);
        chk("rst_bus", {7'd0, ram_sel, ram_addr, ram_wdata}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) step();

        // Single write, grant tied high: minimum latency
        clear_log();
        ram_gnt = 1'b1;
        fir(8'h03, 8'h12, 8'h34);
        step();
        coef_wr_stb = 1'b0;
        chk("lat_req_n1", {30'd0, ram_req, ram_we}, 32'd2);
        chk("lat_pending_n1", {27'd0, pending}, 32'd1);
        step();
        chk("lat_we_n2", {31'd0, ram_we}, 32'd1);
        chk("lat_addr", {24'd0, ram_addr}, 32'h03);
        chk("lat_wdata", {16'd0, ram_wdata}, 32'h1234);
        chk("lat_sel", {31'd0, ram_sel}, 32'd0);
        step();
        chk("lat_idle_after", {31'd0, idle}, 32'd1);
        chk("lat_pending_after", {27'd0, pending}, 32'd0);
        chk("lat_write_count", q_addr.size(), 32'd1);

        // Five strobes into a four-deep queue with no grant
        clear_log();
        ram_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fir(8'h10 + 8'(i), 8'hA0 + 8'(i), 8'h10 + 8'(i));
            step();
        end
        coef_wr_stb = 1'b0;
        chk("full_pending", {27'd0, pending}, 32'd4);
        chk("full_overflow", {31'd0, overflow}, 32'd1);
        chk("full_req_held", {31'd0, ram_req}, 32'd1);
        ram_gnt = 1'b1;
        repeat (12) step();
        chk("full_write_count", q_addr.size(), 32'd4);
        for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
            chk("full_order_addr", {24'd0, q_addr[i]}, 32'h10 + i);
            chk("full_order_data", {16'd0, q_data[i]}, {16'd0, 8'hA0 + 8'(i), 8'h10 + 8'(i)});
        end
        chk("full_idle_end", {31'd0, idle}, 32'd1);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Simultaneous FIR and EQ strobes
        clear_log();
        fir(8'h01, 8'h22, 8'h11);
        eq_wr_stb = 1'b1; eq_select_reg = 8'h02;
        eq_wr_msb_data_reg = 8'h44; eq_wr_lsb_data_reg = 8'h33;
        step();
        coef_wr_stb = 1'b0;
        eq_wr_stb = 1'b0;
        repeat (8) step();
`ifdef EQ_WR_PATH_EN
        chk("dual_write_count", q_addr.size(), 32'd2);
        if (q_addr.size() == 2) begin
            chk("dual_second_addr", {24'd0, q_addr[1]}, 32'h02);
            chk("dual_second_sel", {31'd0, q_sel[1]}, 32'd1);
            chk("dual_second_data", {16'd0, q_data[1]}, 32'h4433);
        end
`else
        chk("dual_write_count", q_addr.size(), 32'd1);
`endif
        if (q_addr.size() >= 1) begin
            chk("dual_first_addr", {24'd0, q_addr[0]}, 32'h01);
            chk("dual_first_sel", {31'd0, q_sel[0]}, 32'd0);
            chk("dual_first_data", {16'd0, q_data[0]}, 32'h2211);
        end
        chk("dual_overflow", {31'd0, overflow}, 32'd0);

        // Grant toggling 1-0-1 with three queued entries
        clear_log();
        ram_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fir(8'h20 + 8'(i), 8'h00, 8'h55);
            step();
        end
        coef_wr_stb = 1'b0;
        chk("tog_pending_start", {27'd0, pending}, 32'd3);
        prev_granted = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ram_gnt = (i % 2 == 0);
            prev_granted = ram_req && ram_gnt;
            step();
            if (ram_we) begin
                chk("tog_we_after_granted_req", {31'd0, prev_granted}, 32'd1);
            end
        end
        chk("tog_write_count", q_pend.size(), 32'd3);
        for (int i = 0; i < 3 && i < q_pend.size(); i++) begin
            chk("tog_pending_step", {27'd0, q_pend[i]}, 32'd3 - i);
            chk("tog_order_addr", {24'd0, q_addr[i]}, 32'h20 + i);
        end
        chk("tog_pending_end", {27'd0, pending}, 32'd0);
        chk("tog_idle_end", {31'd0, idle}, 32'd1);

        // Reset pulsed during WRITE with two entries held
        clear_log();
        ram_gnt = 1'b0;
        fir(8'h30, 8'h01, 8'h02);
        step();
        fir(8'h31, 8'h03, 8'h04);
        step();
        coef_wr_stb = 1'b0;
        ram_gnt = 1'b1;
        step();
        chk("rstw_in_write", {31'd0, ram_we}, 32'd1);
        chk("rstw_pending_before", {27'd0, pending}, 32'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("rstw_we_dropped", {31'd0, ram_we}, 32'd0);
        chk("rstw_pending_zero", {27'd0, pending}, 32'd0);
        chk("rstw_idle", {31'd0, idle}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        clear_log();
        repeat (10) step();
        chk("rstw_no_writes_after", q_addr.size(), 32'd0);
        chk("rstw_pending_after", {27'd0, pending}, 32'd0);

        // Push in the same cycle as a pop while full
        clear_log();
        ram_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fir(8'h40 + 8'(i), 8'hC0, 8'h40 + 8'(i));
            step();
        end
        coef_wr_stb = 1'b0;
        chk("pp_pending_full", {27'd0, pending}, 32'd4);
        ram_gnt = 1'b1;
        step();
        chk("pp_in_write", {31'd0, ram_we}, 32'd1);
        fir(8'h44, 8'hC0, 8'h44);
        step();
        coef_wr_stb = 1'b0;
        chk("pp_pending_stays", {27'd0, pending}, 32'd4);
        chk("pp_no_overflow", {31'd0, overflow}, 32'd0);
        repeat (12) step();
        chk("pp_write_count", q_addr.size(), 32'd5);
        for (int i = 0; i < 5 && i < q_addr.size(); i++) begin
            chk("pp_order_addr", {24'd0, q_addr[i]}, 32'h40 + i);
        end
        chk("pp_idle_end", {31'd0, idle}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/coef_wr_scheduler.md
COEF_WR_SCHEDULER -- requirements
Module: coef_wr_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queued write entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port coef_wr_stb  input  1  one-cycle FIR coefficient write request.
REQ-005 SHALL have port coef_select_reg  input  8  FIR coefficient address.
REQ-006 SHALL have ports coef_wr_lsb_data_reg, coef_wr_msb_data_reg  input  8 each  coefficient data halves.
REQ-007 SHALL have port eq_wr_stb  input  1  one-cycle equalizer gain write request.
REQ-008 SHALL have ports eq_select_reg, eq_wr_lsb_data_reg, eq_wr_msb_data_reg  input  8 each  EQ address and data halves.
REQ-009 SHALL have port ram_gnt  input  1  filter engine releases shared coefficient RAM port this cycle.
REQ-010 SHALL have port ovf_clr  input  1  clears overflow flag.
REQ-011 SHALL have ports ram_req, ram_we, ram_sel (0=FIR, 1=EQ)  output  1 each.
REQ-012 SHALL have ports ram_addr  output  8, ram_wdata  output  16 ({msb,lsb}).
REQ-013 SHALL have ports pending  output  5  queued entry count, overflow  output  1  sticky drop flag, idle  output  1.

Function
REQ-014 On a strobe, SHALL capture {sel, address, msb, lsb} as presented on that cycle into a FIFO tail.
REQ-015 coef_wr_stb and eq_wr_stb in the same cycle: SHALL push FIR entry first, then EQ entry.
REQ-016 Push when FIFO full (after any same-cycle pop): entry SHALL be dropped and overflow set; if only one slot free on a dual strobe, FIR kept, EQ dropped.
REQ-017 overflow SHALL stay set until ovf_clr; set and clear in same cycle: set wins.
REQ-018 FSM states IDLE, REQ, WRITE; IDLE->REQ when FIFO non-empty; REQ->WRITE on ram_gnt=1; WRITE->REQ if entries remain after pop, else IDLE.
REQ-019 ram_req SHALL be 1 exactly while in REQ; ram_we SHALL be 1 exactly one cycle while in WRITE.
REQ-020 During WRITE, ram_sel/ram_addr/ram_wdata SHALL show the FIFO head; head popped at end of WRITE cycle.
REQ-021 Outside WRITE, ram_addr/ram_wdata/ram_sel SHALL be 0.
REQ-022 Minimum latency: strobe cycle N -> ram_req in N+1 -> ram_we in N+2 with ram_gnt high in N+1.
REQ-023 ram_gnt low in REQ SHALL hold REQ indefinitely with no loss or reordering; pushes continue meanwhile.
REQ-024 Push and pop in same cycle SHALL leave pending unchanged; FIFO pointers wrap modulo DEPTH.
REQ-025 pending SHALL equal entries held (0..DEPTH); idle=1 when state IDLE and pending=0.
REQ-026 Writes SHALL reach RAM in strobe order.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, empty FIFO, pending=0, overflow=0, ram_req=0, ram_we=0, ram outputs 0, idle=1.
REQ-028 Reset asserted during REQ or WRITE SHALL abort the write with no ram_we afterwards; queued entries discarded.
REQ-029 Release SHALL be synchronized so first active edge sees consistent state.

Configuration
REQ-030 Macro EQ_WR_PATH_EN: defined -> EQ writes queued as above; undefined -> eq_wr_stb ignored, ram_sel held 0, EQ data inputs unused, FIR behaviour unchanged.

Verification
REQ-031 coef_wr_stb with addr 0x03, data 0x12/0x34, ram_gnt tied 1 -> ram_we 2 cycles later, ram_addr 0x03, ram_wdata 0x1234, ram_sel 0.
REQ-032 Five FIR strobes, ram_gnt 0, DEPTH 4 -> pending 4, overflow 1; raise ram_gnt -> four writes in order, fifth absent; ovf_clr -> overflow 0.
REQ-033 Simultaneous coef (0x01) and eq (0x02) strobes, EQ_WR_PATH_EN defined -> FIR 0x01 written, then EQ 0x02 with ram_sel 1; undefined -> only FIR write.
REQ-034 ram_gnt toggled 1-0-1 per cycle with 3 queued -> each ram_we follows a granted REQ cycle, pending steps 3,2,1,0, idle 1 at end.
REQ-035 reset_n pulsed low during WRITE with 2 pending -> ram_we drops immediately, pending 0, no further writes after release.
REQ-036 Push on same cycle as pop with FIFO full -> entry accepted, pending stays 4, overflow stays 0.
